fp_stream_source: RTL and testbench
===================================

FP_STREAM_SOURCE -- requirements
Module: fp_stream_source

Interface
REQ-001 Parameter WIDTH, default 32: bits per channel word.
REQ-002 Parameter NCH, default 2: number of parallel output channels, i.e. operands per sample.
REQ-003 Parameter NSAMPLES, default 1024: accepted samples before end of stream.
REQ-004 Parameter SEED, default 32'hACE1: LFSR seed and constant-mode value; a zero seed SHALL be replaced by 32'h1.
REQ-005 Parameter SPECIAL_PERIOD, default 16: special-value insertion interval, minimum 2.
REQ-006 CLK  in  1  the only clock, rising edge.
REQ-007 RST_n  in  1  asynchronous, active-low reset.
REQ-008 START  in  1  level-sampled start request, honoured in IDLE only.
REQ-009 MODE  in  2  pattern select, sampled on the start edge: 00 counter, 01 LFSR, 10 walking-one, 11 constant.
REQ-010 READY  in  1  sink accepts the current sample.
REQ-011 VALID  out  1  DATA holds a valid sample.
REQ-012 DATA  out  NCH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH].
REQ-013 COUNT  out  $clog2(NSAMPLES+1)  number of accepted samples.
REQ-014 END_SIM  out  1  stream complete, sticky.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 IDLE -> RUN on the first rising edge with START=1; MODE is latched on that edge, and VALID=1 from the next cycle.
REQ-017 A transfer SHALL occur on each rising edge with VALID=1 and READY=1; COUNT increments by 1 and the next sample is presented on the following cycle.
REQ-018 With VALID=1 and READY=0, DATA and VALID SHALL remain stable; the pattern generator does not advance.
REQ-019 The transfer that brings COUNT to NSAMPLES SHALL move the FSM to DONE: VALID=0 and END_SIM=1 from the next cycle, held until reset.
REQ-020 START and MODE changes in RUN or DONE SHALL be ignored.
REQ-021 Counter mode: channel c = (COUNT + c) mod 2^WIDTH.
REQ-022 LFSR mode: 32-bit Galois LFSR, mask 32'h80200003, advanced once per transfer; channel c = state rotated left by c, truncated or zero-extended to WIDTH.
REQ-023 Walking-one mode: channel c = 1 << ((COUNT + c) mod WIDTH).
REQ-024 Constant mode: every channel = SEED truncated or zero-extended to WIDTH.
REQ-025 Zero-latency output: DATA is registered, and the sample with index k is visible while COUNT=k.

Reset
REQ-026 RST_n=0 SHALL asynchronously force IDLE, VALID=0, DATA=0, COUNT=0, END_SIM=0, the LFSR to SEED and the latched mode to 00.
REQ-027 Reset asserted mid-RUN or in DONE SHALL abort the stream; a new START after release restarts from sample 0.
REQ-028 Reset release SHALL be synchronous to CLK in effect: no transfer on the release edge.

Configuration
REQ-029 Macro FP_STREAM_SOURCE_SPECIAL_EN defined: when WIDTH==32 and k mod SPECIAL_PERIOD == SPECIAL_PERIOD-1, channel c is replaced by table[(k/SPECIAL_PERIOD + c) mod 4].
REQ-030 The special table SHALL be {32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h00000001}; the LFSR still advances on the substituted sample.
REQ-031 Macro undefined, or WIDTH!=32: no substitution and no special-value logic synthesised.

Structure
REQ-032 Package fp_stream_pkg SHALL hold the mode encodings, the FSM state typedef, the LFSR mask, the default seed and the special-value table constants.
REQ-033 Sub-module fp_lfsr32 (enable, 32-bit state, seed load) SHALL implement the LFSR; everything else is in fp_stream_source.

Verification
REQ-034 Reset, START=1, MODE=00, READY=1, NCH=2: DATA ch0/ch1 = 0/1, 1/2, 2/3, ...; END_SIM=1 one cycle after the 1024th transfer.
REQ-035 MODE=01, READY toggling 1,0,0,1: DATA and VALID stable during the stalls; the sequence matches a software LFSR seeded 32'hACE1.
REQ-036 MODE=10, WIDTH=8: ch0 = 8'h01, 02, ..., 80, 01, so wrap occurs at sample 8.
REQ-037 With RST_n pulsed low at COUNT=37: outputs zero immediately; after release, START restarts at COUNT=0 with the first counter value 0.
REQ-038 With FP_STREAM_SOURCE_SPECIAL_EN defined, MODE=00: sample 15 ch0=32'h00000000, ch1=32'h7F800000; sample 31 ch0=32'h7F800000, ch1=32'h7FC00000.
REQ-039 MODE change and START pulse during RUN and in DONE: no effect on DATA, COUNT or END_SIM.

Source files
------------

// File: rtl/fp_stream_pkg.sv
// Shared encodings and constants for the FP test-stream source.
// Holds the pattern modes, FSM states, LFSR polynomial, default seed and special-value table.
package fp_stream_pkg;

  typedef enum logic [1:0] {
    MODE_CNT   = 2'b00,
    MODE_LFSR  = 2'b01,
    MODE_WALK  = 2'b10,
    MODE_CONST = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [31:0] LFSR_MASK    = 32'h80200003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000ACE1;

  // Zero, +Inf, quiet NaN, smallest denormal.
  localparam logic [31:0] SPECIAL_TABLE [4] = '{32'h00000000, 32'h7F800000,
                                                32'h7FC00000, 32'h00000001};

  // Right-shifting Galois step.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0) ? 32'h1 : s;
  endfunction

endpackage

// File: rtl/fp_lfsr32.sv
// 32-bit Galois LFSR with synchronous seed load and advance enable.
// State updates one cycle after en; load has priority over en.
module fp_lfsr32
  import fp_stream_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  output logic [31:0] state
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (en) begin
      state <= lfsr_step(state);
    end
  end

endmodule

// File: rtl/fp_stream_source.sv
// Pattern stream source: sample k is registered on data while count==k; stalls hold data/valid.
// Optional FP special-value substitution (WIDTH==32 only) under FP_STREAM_SOURCE_SPECIAL_EN.
module fp_stream_source
  import fp_stream_pkg::*;
#(
  parameter int          WIDTH          = 32,
  parameter int          NCH            = 2,
  parameter int          NSAMPLES       = 1024,
  parameter logic [31:0] SEED           = DEFAULT_SEED,
  parameter int          SPECIAL_PERIOD = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [1:0]                      mode,
  input  logic                            ready,
  output logic                            valid,
  output logic [NCH*WIDTH-1:0]            data,
  output logic [$clog2(NSAMPLES+1)-1:0]   count,
  output logic                            end_sim
);

  localparam logic [31:0] SEED_EFF = seed_fix(SEED);

  state_t      state;
  mode_t       mode_q;
  logic [31:0] lfsr_state;
  logic        lfsr_load;
  logic        lfsr_en;
  logic [31:0] count_nxt;

  assign lfsr_load = (state == S_IDLE) && start;
  assign lfsr_en   = (state == S_RUN) && ready;
  assign count_nxt = 32'(count) + 32'd1;

  fp_lfsr32 #(.SEED(SEED_EFF)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .en    (lfsr_en),
    .state (lfsr_state)
  );

  function automatic logic [WIDTH-1:0] chan(input mode_t m, input logic [31:0] k,
                                            input logic [31:0] s, input logic [31:0] c);
    logic [WIDTH-1:0] w;
    logic [31:0]      rot;
    rot = (s << c[4:0]) | (s >> (6'd32 - {1'b0, c[4:0]}));
    case (m)
      MODE_CNT:   w = WIDTH'(k + c);
      MODE_LFSR:  w = WIDTH'(rot);
      MODE_WALK:  w = WIDTH'(1) << ((k + c) % WIDTH);
      MODE_CONST: w = WIDTH'(SEED_EFF);
      default:    w = '0;
    endcase
`ifdef FP_STREAM_SOURCE_SPECIAL_EN
    if (WIDTH == 32 && (k % SPECIAL_PERIOD) == SPECIAL_PERIOD - 1)
      w = WIDTH'(SPECIAL_TABLE[2'(k / SPECIAL_PERIOD + c)]);
`endif
    return w;
  endfunction

  function automatic logic [NCH*WIDTH-1:0] build(input mode_t m, input logic [31:0] k,
                                                 input logic [31:0] s);
    logic [NCH*WIDTH-1:0] d;
    d = '0;
    for (int c = 0; c < NCH; c++)
      d[c*WIDTH +: WIDTH] = chan(m, k, s, 32'(c));
    return d;
  endfunction

  // Next sample is built one edge ahead so data is ready the cycle count reaches its index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mode_q  <= MODE_CNT;
      valid   <= 1'b0;
      data    <= '0;
      count   <= '0;
      end_sim <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q <= mode_t'(mode);
            data   <= build(mode_t'(mode), 32'd0, SEED_EFF);
            valid  <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (ready) begin
            count <= count + 1'b1;
            if (count_nxt == 32'(NSAMPLES)) begin
              valid   <= 1'b0;
              end_sim <= 1'b1;
              state   <= S_DONE;
            end else begin
              data <= build(mode_q, count_nxt, lfsr_step(lfsr_state));
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_stream_source.sv
// Directed bench for fp_stream_source: default instance (WIDTH=32) plus a WIDTH=8 instance.
module tb_fp_stream_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic        ready = 1'b0;
  logic        valid;
  logic [63:0] data;
  logic [10:0] count;
  logic        end_sim;

  logic        start8 = 1'b0;
  logic [1:0]  mode8 = 2'b00;
  logic        ready8 = 1'b0;
  logic        valid8;
  logic [15:0] data8;
  logic [10:0] count8;
  logic        end_sim8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_stream_source u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ready(ready),
    .valid(valid), .data(data), .count(count), .end_sim(end_sim)
  );

  fp_stream_source #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .mode(mode8), .ready(ready8),
    .valid(valid8), .data(data8), .count(count8), .end_sim(end_sim8)
  );

  function automatic logic [31:0] sw_step(input logic [31:0] s);
    if (s[0]) return (s >> 1) ^ 32'h80200003;
    else      return s >> 1;
  endfunction

  function automatic logic [63:0] cnt_exp(input int k);
    logic [31:0] c0, c1;
    c0 = 32'(k);
    c1 = 32'(k + 1);
`ifdef FP_STREAM_SOURCE_SPECIAL_EN
    if (k % 16 == 15) begin
      logic [31:0] tbl [4];
      tbl = '{32'h00000000, 32'h7F800000, 32'h7FC00000, 32'h00000001};
      c0 = tbl[(k / 16) % 4];
      c1 = tbl[(k / 16 + 1) % 4];
    end
`endif
    return {c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; mode = 2'b00; ready = 1'b0;
    start8 = 1'b0; mode8 = 2'b00; ready8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", valid); end
    checks++; if (data !== 64'h0) begin failures++; $display("FAIL rst_data got=%h exp=0", data); end
    checks++; if (count !== 11'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", count); end
    checks++; if (end_sim !== 1'b0) begin failures++; $display("FAIL rst_end got=%b exp=0", end_sim); end
  endtask

  task automatic test_counter();
    do_reset();
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0;
    checks++; if (valid !== 1'b1 || data !== 64'h00000001_00000000 || count !== 11'd0) begin
      failures++; $display("FAIL cnt_first got=%b/%h/%0d exp=1/0000000100000000/0", valid, data, count);
    end
    ready = 1'b1;
    for (int i = 1; i < 1024; i++) begin
      // Start pulse and mode change mid-run must be ignored.
      if (i == 50) begin start = 1'b1; mode = 2'b11; end
      if (i == 52) begin start = 1'b0; mode = 2'b00; end
      tick();
      checks++; if (count !== 11'(i) || data !== cnt_exp(i) || valid !== 1'b1) begin
        failures++; $display("FAIL cnt_seq i=%0d got=%0d/%h exp=%0d/%h", i, count, data, i, cnt_exp(i));
      end
    end
    checks++; if (end_sim !== 1'b0) begin failures++; $display("FAIL cnt_end_early got=%b exp=0", end_sim); end
    tick();
    checks++; if (valid !== 1'b0 || end_sim !== 1'b1 || count !== 11'd1024) begin
      failures++; $display("FAIL cnt_done got=%b/%b/%0d exp=0/1/1024", valid, end_sim, count);
    end
    start = 1'b1; mode = 2'b01;
    repeat (3) tick();
    start = 1'b0;
    repeat (2) tick();
    checks++; if (valid !== 1'b0 || end_sim !== 1'b1 || count !== 11'd1024) begin
      failures++; $display("FAIL done_sticky got=%b/%b/%0d exp=0/1/1024", valid, end_sim, count);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    start = 1'b1; mode = 2'b00;
    tick();
    start = 1'b0; ready = 1'b1;
    repeat (37) tick();
    checks++; if (count !== 11'd37 || data !== 64'h00000026_00000025) begin
      failures++; $display("FAIL mid_pre got=%0d/%h exp=37/0000002600000025", count, data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid !== 1'b0 || data !== 64'h0 || count !== 11'd0 || end_sim !== 1'b0) begin
      failures++; $display("FAIL mid_async got=%b/%h/%0d/%b exp=0/0/0/0", valid, data, count, end_sim);
    end
    @(negedge clk);
    rst_n = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (valid !== 1'b1 || count !== 11'd0 || data !== 64'h00000001_00000000) begin
      failures++; $display("FAIL mid_restart got=%b/%0d/%h exp=1/0/0000000100000000", valid, count, data);
    end
    tick();
    checks++; if (count !== 11'd1 || data !== 64'h00000002_00000001) begin
      failures++; $display("FAIL mid_next got=%0d/%h exp=1/0000000200000001", count, data);
    end
  endtask

  task automatic test_lfsr();
    logic [31:0] s;
    logic        pat [4];
    int          k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    s = 32'h0000ACE1;
    k = 0;
    do_reset();
    start = 1'b1; mode = 2'b01;
    tick();
    start = 1'b0; mode = 2'b00;
    checks++; if (data !== 64'h000159C2_0000ACE1 || valid !== 1'b1) begin
      failures++; $display("FAIL lfsr_first got=%h exp=000159c20000ace1", data);
    end
    for (int n = 0; n < 16; n++) begin
      ready = pat[n % 4];
      tick();
      if (pat[n % 4]) begin k++; s = sw_step(s); end
      checks++; if (data !== {s[30:0], s[31], s} || count !== 11'(k) || valid !== 1'b1) begin
        failures++; $display("FAIL lfsr_seq n=%0d got=%h/%0d exp=%h/%0d", n, data, count, {s[30:0], s[31], s}, k);
      end
      if (n == 0) begin
        checks++; if (data[31:0] !== 32'h80205673) begin
          failures++; $display("FAIL lfsr_step1 got=%h exp=80205673", data[31:0]);
        end
      end
    end
  endtask

  task automatic test_const();
    do_reset();
    start = 1'b1; mode = 2'b11;
    tick();
    start = 1'b0; ready = 1'b1;
    tick();
    tick();
    checks++; if (data !== 64'h0000ACE1_0000ACE1 || count !== 11'd2) begin
      failures++; $display("FAIL const got=%h/%0d exp=0000ace10000ace1/2", data, count);
    end
  endtask

  task automatic test_walk8();
    logic [7:0] exp0 [10];
    exp0 = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    do_reset();
    start8 = 1'b1; mode8 = 2'b10;
    tick();
    start8 = 1'b0; ready8 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (data8[7:0] !== exp0[i] || data8[15:8] !== exp0[(i + 1) % 8] || count8 !== 11'(i)) begin
        failures++; $display("FAIL walk8 i=%0d got=%h/%0d exp=%h%h/%0d", i, data8, count8, exp0[(i + 1) % 8], exp0[i], i);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_counter();
    test_reset_mid();
    test_lfsr();
    test_const();
    test_walk8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
